// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types for the ID-stage hazard/forwarding logic:
// register address width, scoreboard entry layout and stage indices.
package mips_pipe_pkg;

    localparam int unsigned REG_AW = 5;

    localparam int unsigned SB_EX  = 0;
    localparam int unsigned SB_MEM = 1;
    localparam int unsigned SB_WB  = 2;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] waddr;
        logic              is_load;
    } sb_entry_t;

endpackage

// File: rtl/branch_fwd_ctrl_fwd_match.sv
// Per-operand scoreboard lookup: reports which in-flight stages write the
// operand's register. Register 0 and unused operands never hit.
module fwd_match
    import mips_pipe_pkg::*;
(
    input  sb_entry_t         i_ex,
    input  sb_entry_t         i_mem,
    input  sb_entry_t         i_wb,
    input  logic [REG_AW-1:0] i_addr,
    input  logic              i_use,
    output logic              o_hit_ex,
    output logic              o_hit_mem,
    output logic              o_hit_wb,
    output logic              o_ex_load
);

    logic w_en;

    assign w_en      = i_use && (i_addr != '0);
    assign o_hit_ex  = w_en && i_ex.valid  && (i_ex.waddr  == i_addr);
    assign o_hit_mem = w_en && i_mem.valid && (i_mem.waddr == i_addr);
    assign o_hit_wb  = w_en && i_wb.valid  && (i_wb.waddr  == i_addr);
    assign o_ex_load = i_ex.is_load;

endmodule

// File: rtl/branch_fwd_ctrl.sv
// ID-stage branch operand forwarding and stall control over an EX/MEM/WB
// scoreboard. Define BRANCH_FWD_STATS_EN to add stall/forward counters.
module branch_fwd_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned REG_AW   = mips_pipe_pkg::REG_AW,
    parameter int unsigned SB_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_is_branch,
    input  logic              id_use_a,
    input  logic              id_use_b,
    input  logic [REG_AW-1:0] id_raddr_a,
    input  logic [REG_AW-1:0] id_raddr_b,
    input  logic              id_wreg,
    input  logic [REG_AW-1:0] id_waddr,
    input  logic              id_is_load,
    input  logic              pipe_hold,
    input  logic              flush,
    output logic              control_rdata_a,
    output logic              control_rdata_b,
    output logic              stall_id
`ifdef BRANCH_FWD_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt
`endif
);

    generate
        if (SB_DEPTH != 3 || REG_AW != mips_pipe_pkg::REG_AW) begin : g_bad_cfg
            $error("branch_fwd_ctrl: SB_DEPTH must be 3 and REG_AW must match mips_pipe_pkg");
        end
    endgenerate

    sb_entry_t r_sb [SB_DEPTH];
    sb_entry_t w_ex_next;

    logic w_hit_ex_a, w_hit_mem_a, w_hit_wb_a, w_ex_load_a;
    logic w_hit_ex_b, w_hit_mem_b, w_hit_wb_b, w_ex_load_b;
    logic w_branch, w_stall_a, w_stall_b;

    fwd_match u_match_a (
        .i_ex      (r_sb[SB_EX]),
        .i_mem     (r_sb[SB_MEM]),
        .i_wb      (r_sb[SB_WB]),
        .i_addr    (id_raddr_a),
        .i_use     (id_use_a),
        .o_hit_ex  (w_hit_ex_a),
        .o_hit_mem (w_hit_mem_a),
        .o_hit_wb  (w_hit_wb_a),
        .o_ex_load (w_ex_load_a)
    );

    fwd_match u_match_b (
        .i_ex      (r_sb[SB_EX]),
        .i_mem     (r_sb[SB_MEM]),
        .i_wb      (r_sb[SB_WB]),
        .i_addr    (id_raddr_b),
        .i_use     (id_use_b),
        .o_hit_ex  (w_hit_ex_b),
        .o_hit_mem (w_hit_mem_b),
        .o_hit_wb  (w_hit_wb_b),
        .o_ex_load (w_ex_load_b)
    );

    // Branches need the final value on the MEM/WB bus; other consumers only
    // wait out a load still in EX.
    assign w_branch  = id_valid && id_is_branch;
    assign w_stall_a = id_valid && (w_branch ? (w_hit_ex_a || w_hit_mem_a)
                                             : (w_hit_ex_a && w_ex_load_a));
    assign w_stall_b = id_valid && (w_branch ? (w_hit_ex_b || w_hit_mem_b)
                                             : (w_hit_ex_b && w_ex_load_b));

    assign stall_id        = w_stall_a || w_stall_b;
    assign control_rdata_a = w_branch && w_hit_wb_a && !stall_id;
    assign control_rdata_b = w_branch && w_hit_wb_b && !stall_id;

    assign w_ex_next.valid   = id_valid && id_wreg && (id_waddr != '0) && !stall_id && !flush;
    assign w_ex_next.waddr   = id_waddr;
    assign w_ex_next.is_load = id_is_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SB_DEPTH; i++) begin
                r_sb[i] <= '0;
            end
        end else if (!pipe_hold) begin
            r_sb[SB_WB]  <= r_sb[SB_MEM];
            r_sb[SB_MEM] <= r_sb[SB_EX];
            r_sb[SB_EX]  <= w_ex_next;
        end
    end

`ifdef BRANCH_FWD_STATS_EN
    logic [31:0] r_stall_cnt, r_fwd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (stall_id && !pipe_hold && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if ((control_rdata_a || control_rdata_b) && (r_fwd_cnt != '1)) begin
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_branch_fwd_ctrl.sv
// Directed per-cycle vector bench for branch_fwd_ctrl; each table row is one
// clock cycle of ID inputs with hand-derived expected outputs.
module tb_branch_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_is_branch, id_use_a, id_use_b;
    logic [4:0] id_raddr_a, id_raddr_b, id_waddr;
    logic       id_wreg, id_is_load, pipe_hold, flush;
    logic       control_rdata_a, control_rdata_b, stall_id;
`ifdef BRANCH_FWD_STATS_EN
    logic [31:0] stall_cnt, fwd_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_fwd_ctrl #(.REG_AW(5), .SB_DEPTH(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_is_branch    (id_is_branch),
        .id_use_a        (id_use_a),
        .id_use_b        (id_use_b),
        .id_raddr_a      (id_raddr_a),
        .id_raddr_b      (id_raddr_b),
        .id_wreg         (id_wreg),
        .id_waddr        (id_waddr),
        .id_is_load      (id_is_load),
        .pipe_hold       (pipe_hold),
        .flush           (flush),
        .control_rdata_a (control_rdata_a),
        .control_rdata_b (control_rdata_b),
        .stall_id        (stall_id)
`ifdef BRANCH_FWD_STATS_EN
        ,
        .stall_cnt       (stall_cnt),
        .fwd_cnt         (fwd_cnt)
`endif
    );

    typedef struct {
        string      name;
        logic       v, br, ua, ub;
        logic [4:0] ra, rb;
        logic       wr;
        logic [4:0] wa;
        logic       ld, hold, fl;
        logic       ca, cb, st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, bit v, bit br, bit ua, bit ub,
                                int ra, int rb, bit wr, int wa, bit ld,
                                bit hold, bit fl, bit ca, bit cb, bit st);
        vec_t r;
        r.name = name; r.v = v; r.br = br; r.ua = ua; r.ub = ub;
        r.ra = 5'(ra); r.rb = 5'(rb); r.wr = wr; r.wa = 5'(wa); r.ld = ld;
        r.hold = hold; r.fl = fl; r.ca = ca; r.cb = cb; r.st = st;
        return r;
    endfunction

    task automatic bubbles(int n);
        for (int i = 0; i < n; i++)
            vecs.push_back(mk("bubble", 0,0,0,0, 0,0, 0,0,0, 0,0, 0,0,0));
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t r);
        id_valid = r.v; id_is_branch = r.br; id_use_a = r.ua; id_use_b = r.ub;
        id_raddr_a = r.ra; id_raddr_b = r.rb; id_wreg = r.wr; id_waddr = r.wa;
        id_is_load = r.ld; pipe_hold = r.hold; flush = r.fl;
    endtask

    task automatic check_outs(string name, logic ca, logic cb, logic st);
        chk({name, ".ctrl_a"}, {31'd0, control_rdata_a}, {31'd0, ca});
        chk({name, ".ctrl_b"}, {31'd0, control_rdata_b}, {31'd0, cb});
        chk({name, ".stall"},  {31'd0, stall_id},        {31'd0, st});
    endtask

    initial begin
        //                  name      v br ua ub ra rb wr wa ld ho fl ca cb st
        // WB forward: r5 then two independent ALU ops, then beq r5,r0
        vecs.push_back(mk("wb_p",     1,0,0,0,  0, 0, 1, 5,0, 0,0, 0,0,0));
        vecs.push_back(mk("wb_i1",    1,0,1,1,  1, 2, 1, 9,0, 0,0, 0,0,0));
        vecs.push_back(mk("wb_i2",    1,0,1,1,  1, 2, 1,10,0, 0,0, 0,0,0));
        vecs.push_back(mk("wb_beq",   1,1,1,1,  5, 0, 0, 0,0, 0,0, 1,0,0));
        vecs.push_back(mk("wb_gone",  1,1,1,1,  5, 0, 0, 0,0, 0,0, 0,0,0));
        bubbles(3);
        // EX-distance branch: two stalls then WB forward
        vecs.push_back(mk("ex_p",     1,0,1,1,  1, 2, 1, 3,0, 0,0, 0,0,0));
        vecs.push_back(mk("ex_b0",    1,1,1,1,  3, 4, 0, 0,0, 0,0, 0,0,1));
        vecs.push_back(mk("ex_b1",    1,1,1,1,  3, 4, 0, 0,0, 0,0, 0,0,1));
        vecs.push_back(mk("ex_b2",    1,1,1,1,  3, 4, 0, 0,0, 0,0, 1,0,0));
        bubbles(3);
        // Load-use then a branch on an EX producer with the other operand in WB
        vecs.push_back(mk("lu_lw",    1,0,1,0,  1, 0, 1, 7,1, 0,0, 0,0,0));
        vecs.push_back(mk("lu_use0",  1,0,1,1,  7, 1, 1, 8,0, 0,0, 0,0,1));
        vecs.push_back(mk("lu_use1",  1,0,1,1,  7, 1, 1, 8,0, 0,0, 0,0,0));
        vecs.push_back(mk("lu_br0",   1,1,1,1,  7, 8, 0, 0,0, 0,0, 0,0,1));
        vecs.push_back(mk("lu_br1",   1,1,1,1,  7, 8, 0, 0,0, 0,0, 0,0,1));
        vecs.push_back(mk("lu_br2",   1,1,1,1,  7, 8, 0, 0,0, 0,0, 0,1,0));
        bubbles(3);
        // Register zero never tracked or matched
        vecs.push_back(mk("r0_w",     1,0,0,0,  0, 0, 1, 0,0, 0,0, 0,0,0));
        vecs.push_back(mk("r0_b0",    1,1,1,1,  0, 0, 0, 0,0, 0,0, 0,0,0));
        vecs.push_back(mk("r0_b1",    1,1,1,1,  0, 0, 0, 0,0, 0,0, 0,0,0));
        vecs.push_back(mk("r0_b2",    1,1,1,1,  0, 0, 0, 0,0, 0,0, 0,0,0));
        bubbles(3);
        // Same register on both operands
        vecs.push_back(mk("same_p",   1,0,0,0,  0, 0, 1, 6,0, 0,0, 0,0,0));
        bubbles(2);
        vecs.push_back(mk("same_b",   1,1,1,1,  6, 6, 0, 0,0, 0,0, 1,1,0));
        bubbles(3);
        // Non-load EX hit on ALU consumer, then operands in different stages
        vecs.push_back(mk("dif_p11",  1,0,0,0,  0, 0, 1,11,0, 0,0, 0,0,0));
        vecs.push_back(mk("dif_p12",  1,0,1,0, 11, 0, 1,12,0, 0,0, 0,0,0));
        vecs.push_back(mk("dif_b0",   1,1,1,1, 11,12, 0, 0,0, 0,0, 0,0,1));
        vecs.push_back(mk("dif_b1",   1,1,1,1, 11,12, 0, 0,0, 0,0, 0,0,1));
        vecs.push_back(mk("dif_b2",   1,1,1,1, 11,12, 0, 0,0, 0,0, 0,1,0));
        bubbles(3);
        // Three hold cycles inside a two-cycle branch stall
        vecs.push_back(mk("hd_p",     1,0,0,0,  0, 0, 1, 3,0, 0,0, 0,0,0));
        vecs.push_back(mk("hd_h0",    1,1,1,1,  3, 4, 0, 0,0, 1,0, 0,0,1));
        vecs.push_back(mk("hd_h1",    1,1,1,1,  3, 4, 0, 0,0, 1,0, 0,0,1));
        vecs.push_back(mk("hd_h2",    1,1,1,1,  3, 4, 0, 0,0, 1,0, 0,0,1));
        vecs.push_back(mk("hd_s0",    1,1,1,1,  3, 4, 0, 0,0, 0,0, 0,0,1));
        vecs.push_back(mk("hd_s1",    1,1,1,1,  3, 4, 0, 0,0, 0,0, 0,0,1));
        vecs.push_back(mk("hd_fwd",   1,1,1,1,  3, 4, 0, 0,0, 0,0, 1,0,0));
        bubbles(3);
        // Flushed producer is never inserted
        vecs.push_back(mk("fl_p",     1,0,0,0,  0, 0, 1, 3,0, 0,1, 0,0,0));
        vecs.push_back(mk("fl_b",     1,1,1,1,  3, 4, 0, 0,0, 0,0, 0,0,0));
        bubbles(3);
        // Flush together with stall: stall still reported, bubble inserted
        vecs.push_back(mk("fs_lw",    1,0,0,0,  0, 0, 1,21,1, 0,0, 0,0,0));
        vecs.push_back(mk("fs_use",   1,0,1,0, 21, 0, 1,22,0, 0,1, 0,0,1));
        vecs.push_back(mk("fs_br",    1,1,1,1, 22, 0, 0, 0,0, 0,0, 0,0,0));
        bubbles(3);

        // Reset state: outputs zero even with a branch presented in ID
        rst = 1'b1;
        drive(mk("rst", 1,1,1,1, 1,2, 0,0,0, 0,0, 0,0,0));
        #3;
        check_outs("reset", 1'b0, 1'b0, 1'b0);
`ifdef BRANCH_FWD_STATS_EN
        chk("reset.stall_cnt", stall_cnt, 32'd0);
        chk("reset.fwd_cnt", fwd_cnt, 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            check_outs(vecs[i].name, vecs[i].ca, vecs[i].cb, vecs[i].st);
            @(posedge clk);
            #1;
        end

        // Reset asserted mid-stall clears the stall asynchronously
        drive(mk("rm_p", 1,0,0,0, 0,0, 1,3,0, 0,0, 0,0,0));
        @(posedge clk);
        #1 drive(mk("rm_b", 1,1,1,1, 3,4, 0,0,0, 0,0, 0,0,1));
        #2;
        check_outs("rstmid.before", 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check_outs("rstmid.async", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_outs("rstmid.after", 1'b0, 1'b0, 1'b0);
`ifdef BRANCH_FWD_STATS_EN
        chk("rstmid.stall_cnt", stall_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
